dff_sig_compactor: RTL
======================

DFF_SIG_COMPACTOR -- requirements
Module: dff_sig_compactor

Interface
REQ-001 SHALL have parameter FRAMES, default 256, meaning the number of q samples compacted per run (legal 1..65535).
REQ-002 SHALL have parameter POLY, default 64'h000000000000001B, meaning the MISR feedback taps (x^64+x^4+x^3+x+1).
REQ-003 SHALL have parameter EXP_SIG, default 64'h0, meaning the expected signature (used only under REQ-021).
REQ-004 clk  input  1  single clock, rising-edge; one clock, reset asynchronous active-high.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 q  input  64  register-bank outputs under test (64 CC_DFF Q lines).
REQ-007 start  input  1  begin a compaction run.
REQ-008 shift_en  input  1  advance serial signature readout by one bit.
REQ-009 busy  output  1  high while sampling q.
REQ-010 done  output  1  high while a finished signature is held or being read out.
REQ-011 sig_out  output  1  current MSB of the signature register.
REQ-012 frame_cnt  output  16  samples taken in current/last run.

Function
REQ-013 States SHALL be IDLE, RUN, DONE; busy = (RUN), done = (DONE), registered state, no output combinational from inputs.
REQ-014 IDLE with start=1 at an edge SHALL go to RUN and clear misr and frame_cnt to 0 on that edge; q not sampled on that edge.
REQ-015 RUN SHALL sample q at every edge: misr <= {misr[62:0],1'b0} ^ (misr[63] ? POLY : 0) ^ q; frame_cnt <= frame_cnt+1.
REQ-016 The sample that makes frame_cnt equal FRAMES SHALL also move state to DONE; exactly FRAMES samples per run, taken on the FRAMES edges after the start edge.
REQ-017 start SHALL be ignored in RUN; start in DONE SHALL restart per REQ-014 (readout abandoned).
REQ-018 sig_out SHALL equal misr[63] in all states; in DONE, each edge with shift_en=1 shifts misr left by one, filling 0, and increments a 7-bit shift count.
REQ-019 On the 64th readout shift the state SHALL return to IDLE; misr then 0, frame_cnt retained; shift_en outside DONE ignored; start and shift_en together in DONE -> start wins.

Reset
REQ-020 rst=1 SHALL asynchronously force state IDLE, misr 0, frame_cnt 0, shift count 0, hence busy=0, done=0, sig_out=0, including mid-RUN or mid-readout; first run after release requires a new start.

Configuration
REQ-021 With macro DFF_SIG_COMPACTOR_XCHK_EN defined, SHALL add output port match (1 bit) = done & (misr == EXP_SIG) evaluated on the unshifted signature, latched at DONE entry and held until leaving DONE; reset value 0.
REQ-022 Without DFF_SIG_COMPACTOR_XCHK_EN, the match port and its compare logic SHALL be absent; all other behaviour identical.

Verification
REQ-023 FRAMES=256, q=0 constant, start pulse -> busy 256 cycles, done next, frame_cnt=256, 64 readout shifts all sig_out=0, then IDLE.
REQ-024 FRAMES=2, q=64'h1 then 64'h0 -> signature 64'h2; readout with shift_en held: sig_out 0 for shifts 1-62, 1 on bit 63 of sequence (pre-shift 63), 0 last; done drops after 64th shift.
REQ-025 FRAMES=65, q=64'h1 first sample then 0 -> after 64 samples misr=64'h8000000000000000, final signature 64'h1B (feedback wrap check).
REQ-026 FRAMES=256, rst asserted at frame_cnt=100 asynchronously -> busy, done, sig_out, frame_cnt 0 immediately; start ignored while rst=1; new run after release completes normally.
REQ-027 DONE with 10 bits read, then start=1 and shift_en=1 same edge -> RUN, misr and frame_cnt 0; start asserted in RUN at cnt=5 -> no effect, frame_cnt continues to FRAMES.
REQ-028 XCHK build, FRAMES=2, EXP_SIG=64'h2, q=1 then 0 -> match=1 throughout DONE; EXP_SIG=64'h3 -> match=0.

Source files
------------

// File: rtl/dff_sig_compactor.sv
// 64-bit MISR signature compactor for a CC_DFF register bank, with serial MSB-first readout.
// Optional DFF_SIG_COMPACTOR_XCHK_EN adds a 'match' port comparing the signature to EXP_SIG.
module dff_sig_compactor #(
  parameter int unsigned FRAMES  = 256,
  parameter logic [63:0] POLY    = 64'h000000000000001B,
  parameter logic [63:0] EXP_SIG = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] q,
  input  logic        start,
  input  logic        shift_en,
  output logic        busy,
  output logic        done,
  output logic        sig_out,
`ifdef DFF_SIG_COMPACTOR_XCHK_EN
  output logic        match,
`endif
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] FRAMES_C = 16'(FRAMES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] misr_q, misr_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [6:0]  scnt_q, scnt_d;
`ifdef DFF_SIG_COMPACTOR_XCHK_EN
  logic        match_q, match_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      misr_q  <= '0;
      fcnt_q  <= '0;
      scnt_q  <= '0;
`ifdef DFF_SIG_COMPACTOR_XCHK_EN
      match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      misr_q  <= misr_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
`ifdef DFF_SIG_COMPACTOR_XCHK_EN
      match_q <= match_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    misr_d  = misr_q;
    fcnt_d  = fcnt_q;
    scnt_d  = scnt_q;
`ifdef DFF_SIG_COMPACTOR_XCHK_EN
    match_d = match_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          misr_d  = '0;
          fcnt_d  = '0;
          scnt_d  = '0;
        end
      end
      RUN: begin
        misr_d = {misr_q[62:0], 1'b0} ^ (misr_q[63] ? POLY : 64'h0) ^ q;
        fcnt_d = fcnt_q + 16'd1;
        if (fcnt_d == FRAMES_C) begin
          state_d = DONE;
          scnt_d  = '0;
`ifdef DFF_SIG_COMPACTOR_XCHK_EN
          // Compare the full signature before any readout shift disturbs it.
          match_d = (misr_d == EXP_SIG);
`endif
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
          misr_d  = '0;
          fcnt_d  = '0;
          scnt_d  = '0;
`ifdef DFF_SIG_COMPACTOR_XCHK_EN
          match_d = 1'b0;
`endif
        end else if (shift_en) begin
          misr_d = {misr_q[62:0], 1'b0};
          scnt_d = scnt_q + 7'd1;
          if (scnt_q == 7'd63) begin
            state_d = IDLE;
            scnt_d  = '0;
`ifdef DFF_SIG_COMPACTOR_XCHK_EN
            match_d = 1'b0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sig_out   = misr_q[63];
  assign frame_cnt = fcnt_q;
`ifdef DFF_SIG_COMPACTOR_XCHK_EN
  assign match     = match_q;
`endif

endmodule
